// File: rtl/exception_commit_pkg.sv
// Shared CPU definitions: pipeline exception flags, ExcCode values, commit FSM states.
// TLB-related flags are only honoured when TLB_EXC_EN is defined.
package exception_commit_pkg;

  localparam int unsigned EXC_FLAG_W  = 19;
  localparam int unsigned EXC_CODE_W  = 5;
  localparam int unsigned VPN2_W      = 19;

  // Highest priority in the MSB.
  typedef struct packed {
    logic Interrupt;
    logic WrongAddressinIF;
    logic TLBRefillinIF;
    logic TLBInvalidinIF;
    logic ReservedInstruction;
    logic CoprocessorUnusable;
    logic Syscall;
    logic Break;
    logic Overflow;
    logic Trap;
    logic RdWrongAddressinMEM;
    logic WrWrongAddressinMEM;
    logic RdTLBRefillinMEM;
    logic RdTLBInvalidinMEM;
    logic WrTLBRefillinMEM;
    logic WrTLBInvalidinMEM;
    logic TLBModified;
    logic Eret;
    logic Refetch;
  } ExceptinPipeType;

  // Bit positions of all TLB*/TLBModified flags within ExceptinPipeType.
  localparam logic [EXC_FLAG_W-1:0] TLB_FLAG_MASK = 19'b0011000000001111100;

  localparam logic [EXC_CODE_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_CODE_W-1:0] EXC_MOD  = 5'd1;
  localparam logic [EXC_CODE_W-1:0] EXC_TLBL = 5'd2;
  localparam logic [EXC_CODE_W-1:0] EXC_TLBS = 5'd3;
  localparam logic [EXC_CODE_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_CODE_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_CODE_W-1:0] EXC_SYS  = 5'd8;
  localparam logic [EXC_CODE_W-1:0] EXC_BP   = 5'd9;
  localparam logic [EXC_CODE_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_CODE_W-1:0] EXC_CPU  = 5'd11;
  localparam logic [EXC_CODE_W-1:0] EXC_OV   = 5'd12;
  localparam logic [EXC_CODE_W-1:0] EXC_TR   = 5'd13;

  typedef enum logic [1:0] {
    BADV_NONE,
    BADV_PC,
    BADV_DATA
  } badvaddr_sel_e;

  typedef enum logic {
    IDLE,
    REDIRECT
  } exc_state_e;

endpackage

// File: rtl/exception_commit_priority_enc.sv
// Fixed-priority encoder: exception flags -> ExcCode, Eret/Refetch, BadVAddr source.
// With TLB_EXC_EN undefined every TLB*/TLBModified flag is masked off.
module exc_priority_enc
  import exception_commit_pkg::*;
(
  input  ExceptinPipeType        flags,
  output logic                   any_c,
  output logic                   coded_c,
  output logic [EXC_CODE_W-1:0]  exc_code_c,
  output logic                   is_eret_c,
  output logic                   is_refetch_c,
  output logic                   is_tlb_c,
  output logic                   is_refill_c,
  output badvaddr_sel_e          badvaddr_sel_c
);

`ifdef TLB_EXC_EN
  localparam logic [EXC_FLAG_W-1:0] FLAG_MASK = {EXC_FLAG_W{1'b1}};
`else
  localparam logic [EXC_FLAG_W-1:0] FLAG_MASK = ~TLB_FLAG_MASK;
`endif

  logic [EXC_FLAG_W-1:0] flag_vec;
  ExceptinPipeType       f;

  assign flag_vec = flags & FLAG_MASK;
  assign f        = ExceptinPipeType'(flag_vec);
  assign any_c    = |flag_vec;

  // Walk flags highest priority first; first hit wins.
  always_comb begin
    coded_c        = 1'b1;
    exc_code_c     = EXC_INT;
    is_eret_c      = 1'b0;
    is_refetch_c   = 1'b0;
    is_tlb_c       = 1'b0;
    is_refill_c    = 1'b0;
    badvaddr_sel_c = BADV_NONE;
    if (f.Interrupt) begin
      exc_code_c = EXC_INT;
    end else if (f.WrongAddressinIF) begin
      exc_code_c     = EXC_ADEL;
      badvaddr_sel_c = BADV_PC;
    end else if (f.TLBRefillinIF) begin
      exc_code_c     = EXC_TLBL;
      badvaddr_sel_c = BADV_PC;
      is_tlb_c       = 1'b1;
      is_refill_c    = 1'b1;
    end else if (f.TLBInvalidinIF) begin
      exc_code_c     = EXC_TLBL;
      badvaddr_sel_c = BADV_PC;
      is_tlb_c       = 1'b1;
    end else if (f.ReservedInstruction) begin
      exc_code_c = EXC_RI;
    end else if (f.CoprocessorUnusable) begin
      exc_code_c = EXC_CPU;
    end else if (f.Syscall) begin
      exc_code_c = EXC_SYS;
    end else if (f.Break) begin
      exc_code_c = EXC_BP;
    end else if (f.Overflow) begin
      exc_code_c = EXC_OV;
    end else if (f.Trap) begin
      exc_code_c = EXC_TR;
    end else if (f.RdWrongAddressinMEM) begin
      exc_code_c     = EXC_ADEL;
      badvaddr_sel_c = BADV_DATA;
    end else if (f.WrWrongAddressinMEM) begin
      exc_code_c     = EXC_ADES;
      badvaddr_sel_c = BADV_DATA;
    end else if (f.RdTLBRefillinMEM) begin
      exc_code_c     = EXC_TLBL;
      badvaddr_sel_c = BADV_DATA;
      is_tlb_c       = 1'b1;
      is_refill_c    = 1'b1;
    end else if (f.RdTLBInvalidinMEM) begin
      exc_code_c     = EXC_TLBL;
      badvaddr_sel_c = BADV_DATA;
      is_tlb_c       = 1'b1;
    end else if (f.WrTLBRefillinMEM) begin
      exc_code_c     = EXC_TLBS;
      badvaddr_sel_c = BADV_DATA;
      is_tlb_c       = 1'b1;
      is_refill_c    = 1'b1;
    end else if (f.WrTLBInvalidinMEM) begin
      exc_code_c     = EXC_TLBS;
      badvaddr_sel_c = BADV_DATA;
      is_tlb_c       = 1'b1;
    end else if (f.TLBModified) begin
      exc_code_c     = EXC_MOD;
      badvaddr_sel_c = BADV_DATA;
      is_tlb_c       = 1'b1;
    end else if (f.Eret) begin
      coded_c   = 1'b0;
      is_eret_c = 1'b1;
    end else if (f.Refetch) begin
      coded_c      = 1'b0;
      is_refetch_c = 1'b1;
    end else begin
      coded_c = 1'b0;
    end
  end

endmodule

// File: rtl/exception_commit.sv
// MEM-stage exception commit: CP0 exception registers, pipeline flush and IF redirect handshake.
// TLB_EXC_EN enables TLB refill/invalid/modified exceptions and the EntryHi.VPN2 update.
module exception_commit
  import exception_commit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR_BASE = 32'hBFC0_0380,
  parameter logic [31:0] TLBR_VECTOR     = 32'hBFC0_0200
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  MEM_Valid,
  input  logic                  MEM_Stall,
  input  ExceptinPipeType       MEM_ExceptType,
  input  logic [31:0]           MEM_PC,
  input  logic                  MEM_IsInDelaySlot,
  input  logic [31:0]           MEM_DataVAddr,
  input  logic                  Redirect_Ready,
  output logic                  Flush_All,
  output logic                  Redirect_Valid,
  output logic [31:0]           Redirect_PC,
  output logic [31:0]           CP0_EPC,
  output logic [31:0]           CP0_BadVAddr,
  output logic                  CP0_Status_EXL,
  output logic                  CP0_Cause_BD,
  output logic [EXC_CODE_W-1:0] CP0_Cause_ExcCode,
  output logic                  Exc_EntryHi_We,
  output logic [VPN2_W-1:0]     Exc_EntryHi_VPN2
);

  logic                  enc_any;
  logic                  enc_coded;
  logic [EXC_CODE_W-1:0] enc_code;
  logic                  enc_eret;
  logic                  enc_refetch;
  logic                  enc_tlb;
  logic                  enc_refill;
  badvaddr_sel_e         enc_badv_sel;

  exc_priority_enc u_enc (
    .flags          (MEM_ExceptType),
    .any_c          (enc_any),
    .coded_c        (enc_coded),
    .exc_code_c     (enc_code),
    .is_eret_c      (enc_eret),
    .is_refetch_c   (enc_refetch),
    .is_tlb_c       (enc_tlb),
    .is_refill_c    (enc_refill),
    .badvaddr_sel_c (enc_badv_sel)
  );

  exc_state_e            state_q, state_d;
  logic [31:0]           epc_q, epc_d;
  logic [31:0]           badvaddr_q, badvaddr_d;
  logic [EXC_CODE_W-1:0] exc_code_q, exc_code_d;
  logic                  bd_q, bd_d;
  logic                  exl_q, exl_d;
  logic [31:0]           redirect_pc_q, redirect_pc_d;
  logic                  entryhi_we_q, entryhi_we_d;
  logic [VPN2_W-1:0]     entryhi_vpn2_q, entryhi_vpn2_d;

  logic                  commit_c;
  logic [31:0]           badv_src_c;
  logic [31:0]           exc_vec_c;

  assign commit_c   = (state_q == IDLE) && MEM_Valid && !MEM_Stall && enc_any;
  assign badv_src_c = (enc_badv_sel == BADV_PC) ? MEM_PC : MEM_DataVAddr;
  // Refill vector only applies when not already at exception level.
  assign exc_vec_c  = (enc_refill && !exl_q) ? TLBR_VECTOR : EXC_VECTOR_BASE;

  always_comb begin
    state_d        = state_q;
    epc_d          = epc_q;
    badvaddr_d     = badvaddr_q;
    exc_code_d     = exc_code_q;
    bd_d           = bd_q;
    exl_d          = exl_q;
    redirect_pc_d  = redirect_pc_q;
    entryhi_we_d   = 1'b0;
    entryhi_vpn2_d = entryhi_vpn2_q;
    unique case (state_q)
      IDLE: begin
        if (commit_c) begin
          state_d = REDIRECT;
          if (enc_coded) begin
            exc_code_d    = enc_code;
            exl_d         = 1'b1;
            redirect_pc_d = exc_vec_c;
            if (!exl_q) begin
              epc_d = MEM_IsInDelaySlot ? (MEM_PC - 32'd4) : MEM_PC;
              bd_d  = MEM_IsInDelaySlot;
            end
            if (enc_badv_sel != BADV_NONE) begin
              badvaddr_d = badv_src_c;
            end
            if (enc_tlb) begin
              entryhi_we_d   = 1'b1;
              entryhi_vpn2_d = badv_src_c[31:13];
            end
          end else if (enc_eret) begin
            exl_d         = 1'b0;
            redirect_pc_d = epc_q;
          end else begin
            redirect_pc_d = MEM_PC;
          end
        end
      end
      REDIRECT: begin
        if (Redirect_Ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= IDLE;
      epc_q          <= 32'd0;
      badvaddr_q     <= 32'd0;
      exc_code_q     <= EXC_INT;
      bd_q           <= 1'b0;
      exl_q          <= 1'b1;
      redirect_pc_q  <= 32'd0;
      entryhi_we_q   <= 1'b0;
      entryhi_vpn2_q <= '0;
    end else begin
      state_q        <= state_d;
      epc_q          <= epc_d;
      badvaddr_q     <= badvaddr_d;
      exc_code_q     <= exc_code_d;
      bd_q           <= bd_d;
      exl_q          <= exl_d;
      redirect_pc_q  <= redirect_pc_d;
      entryhi_we_q   <= entryhi_we_d;
      entryhi_vpn2_q <= entryhi_vpn2_d;
    end
  end

  assign Flush_All         = commit_c && resetn;
  assign Redirect_Valid    = (state_q == REDIRECT);
  assign Redirect_PC       = redirect_pc_q;
  assign CP0_EPC           = epc_q;
  assign CP0_BadVAddr      = badvaddr_q;
  assign CP0_Status_EXL    = exl_q;
  assign CP0_Cause_BD      = bd_q;
  assign CP0_Cause_ExcCode = exc_code_q;
  assign Exc_EntryHi_We    = entryhi_we_q;
  assign Exc_EntryHi_VPN2  = entryhi_vpn2_q;

endmodule
